predictor_branch: RTL
=====================

# predictor_branch

Branch resolution and prediction unit for the pipelined RV32I core; successor to the combinational branch-condition block. It evaluates all six RV32I branch conditions on XLEN-bit operands, holds a table of 2-bit saturating counters indexed by PC, and gives fetch a taken/not-taken prediction. On resolution it registers the outcome and a mispredict flag for the pipeline flush logic, and maintains saturating branch and mispredict statistics counters.

## Interface
- XLEN, 32, operand and PC width
- ENTRADAS, 16, number of predictor table entries; power of two, 2..256
- CW, 16, width of the statistics counters
- clk  in  1  rising-edge clock
- nreset  in  1  asynchronous active-low reset
- pred_pc  in  XLEN  PC of the instruction being fetched
- pred_taken  out  1  prediction for pred_pc; combinational
- res_valid  in  1  a branch is being resolved this cycle
- res_pc  in  XLEN  PC of the resolving branch
- res_funct3  in  3  branch funct3
- res_a  in  XLEN  rs1 value
- res_b  in  XLEN  rs2 value
- res_pred  in  1  prediction originally issued for this branch
- out_valid  out  1  registered result valid
- z_branch  out  1  registered taken outcome
- mispredict  out  1  registered; z_branch differs from res_pred
- ilegal  out  1  registered; funct3 is 010 or 011
- stat_clr  in  1  synchronous clear of the statistics counters
- n_branch  out  CW  count of valid resolved branches
- n_mispredict  out  CW  count of mispredicts

## Operation
- Index: pc[log2(ENTRADAS)+1:2]. Bits [1:0] are ignored.
- Condition evaluation on res_a and res_b:
  - 000 BEQ: equal.
  - 001 BNE: not equal.
  - 100 BLT: signed less-than.
  - 101 BGE: signed greater-or-equal.
  - 110 BLTU: unsigned less-than.
  - 111 BGEU: unsigned greater-or-equal.
  - 010 and 011: not taken, ilegal=1.
- Signed compare uses full XLEN two's complement. Example: 0x80000000 < 0x00000001 signed is true; unsigned it is false.
- Table entries are 2-bit counters:
  - pred_taken = msb of entry[index(pred_pc)].
  - On a valid, legal res_valid: taken increments the entry, saturating at 11; not taken decrements it, saturating at 00.
  - Illegal funct3 leaves the table unchanged.
- mispredict = z_branch XOR res_pred. It is forced to 0 when ilegal=1.
- n_branch increments on every res_valid with legal funct3. n_mispredict increments when that resolution mispredicts. Both saturate at all-ones and never wrap.
- stat_clr zeroes both counters. It wins over a simultaneous increment (result 0). It does not affect the table.

## Timing
- Reset (nreset low, asynchronous): every table entry = 01 (weakly not taken); out_valid, z_branch, mispredict, ilegal = 0; n_branch and n_mispredict = 0. pred_taken therefore reads 0 for any PC.
- Reset asserted mid-operation discards any pending result; out_valid is 0 on the next edge after release.
- pred_taken: zero latency, combinational from the table registers.
- Resolution: 1-cycle latency. With res_valid high at edge N, out_valid, z_branch, mispredict and ilegal are valid after edge N and held for one cycle only.
- res_valid low at an edge: out_valid=0 and all other result outputs=0.
- Back-to-back res_valid every cycle is supported; there is no stall and no ready signal.
- Table update takes effect at edge N. If pred_pc maps to the index being updated in the same cycle, pred_taken returns the pre-update value; the new value is visible from cycle N+1.
- Statistics update at edge N, visible from cycle N+1.

## Test plan
- Reset, then sweep pred_pc over all entries -> pred_taken=0 everywhere. Statistics counters = 0.
- res_funct3=100, a=0xFFFFFFFF, b=1 -> z_branch=1. Same operands with 110 -> z_branch=0. 101 with a=b=5 -> 1. Also cover BEQ, BNE and BGEU. Each result is registered one cycle after res_valid.
- Three taken resolutions at pc=0x40 -> entry 01→10→11→11 (saturates). pred_taken(0x40)=1 from the cycle after the first update. With ENTRADAS=16, pc=0x80 aliases to the same entry and reads identically.
- Simultaneous lookup and update of the same index -> pred_taken shows the old value that cycle and the new value the next.
- funct3=011 -> ilegal=1, z_branch=0, mispredict=0; table and counters unchanged. A res_pred=1 with a not-taken BEQ -> mispredict=1, n_mispredict+1.
- Statistics: preload to all-ones (CW=4, 15 resolutions) -> holds at 15. stat_clr together with res_valid -> counters 0. Assert nreset mid-burst -> all outputs 0 immediately and entries back to 01.

Source files
------------

// File: rtl/predictor_branch.sv
// RV32I branch resolution with a PC-indexed table of 2-bit saturating counters.
// Fetch gets a combinational prediction; resolutions are registered one cycle later with statistics.
module predictor_branch #(
   parameter int XLEN     = 32,
   parameter int ENTRADAS = 16,
   parameter int CW       = 16
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic [XLEN-1:0] pred_pc,
   output logic            pred_taken,
   input  logic            res_valid,
   input  logic [XLEN-1:0] res_pc,
   input  logic [2:0]      res_funct3,
   input  logic [XLEN-1:0] res_a,
   input  logic [XLEN-1:0] res_b,
   input  logic            res_pred,
   output logic            out_valid,
   output logic            z_branch,
   output logic            mispredict,
   output logic            ilegal,
   input  logic            stat_clr,
   output logic [CW-1:0]   n_branch,
   output logic [CW-1:0]   n_mispredict
);

   localparam int IW = $clog2(ENTRADAS);

   logic [1:0]    tbl [ENTRADAS];
   logic [IW-1:0] pred_idx;
   logic [IW-1:0] res_idx;
   logic          legal_p0;
   logic          taken_p0;
   logic          mis_p0;
   logic          unused_pc_bits;

   function automatic logic branch_taken(input logic [2:0]      f3,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      sa = a;
      sb = b;
      case (f3)
         3'b000:  branch_taken = (a == b);
         3'b001:  branch_taken = (a != b);
         3'b100:  branch_taken = (sa < sb);
         3'b101:  branch_taken = (sa >= sb);
         3'b110:  branch_taken = (a < b);
         3'b111:  branch_taken = (a >= b);
         default: branch_taken = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] sat_ctr2(input logic [1:0] c, input logic up);
      if (up) sat_ctr2 = (c == 2'b11) ? c : c + 2'd1;
      else    sat_ctr2 = (c == 2'b00) ? c : c - 2'd1;
   endfunction

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      sat_inc = (&c) ? c : c + CW'(1);
   endfunction

   // Word-aligned PCs: bits [1:0] and everything above the index are don't-care
   assign pred_idx       = pred_pc[IW+1:2];
   assign res_idx        = res_pc[IW+1:2];
   assign unused_pc_bits = ^{pred_pc[1:0], pred_pc[XLEN-1:IW+2], res_pc[1:0], res_pc[XLEN-1:IW+2]};

   // Stage p0: combinational lookup and condition evaluation
   assign pred_taken = tbl[pred_idx][1];

   always_comb begin
      legal_p0 = (res_funct3[2:1] != 2'b01);
      taken_p0 = legal_p0 & branch_taken(res_funct3, res_a, res_b);
      mis_p0   = legal_p0 & (taken_p0 ^ res_pred);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < ENTRADAS; i++) tbl[i] <= 2'b01;
      end else if (res_valid && legal_p0) begin
         tbl[res_idx] <= sat_ctr2(tbl[res_idx], taken_p0);
      end
   end

   // Stage p1: registered resolution, held for a single cycle
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         out_valid  <= 1'b0;
         z_branch   <= 1'b0;
         mispredict <= 1'b0;
         ilegal     <= 1'b0;
      end else begin
         out_valid  <= res_valid;
         z_branch   <= res_valid & taken_p0;
         mispredict <= res_valid & mis_p0;
         ilegal     <= res_valid & ~legal_p0;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         n_branch     <= '0;
         n_mispredict <= '0;
      end else if (stat_clr) begin
         n_branch     <= '0;
         n_mispredict <= '0;
      end else if (res_valid && legal_p0) begin
         n_branch <= sat_inc(n_branch);
         if (mis_p0) n_mispredict <= sat_inc(n_mispredict);
      end
   end

endmodule
